depth_test_stage: RTL
=====================

DEPTH_TEST_STAGE -- requirements
Module: depth_test_stage

Interface
REQ-001 The module SHALL have parameter ZWIDTH, default 16, meaning signed depth width.
REQ-002 The module SHALL have parameter FB_HRES, default 320, meaning framebuffer width in pixels.
REQ-003 The module SHALL have parameter FB_VRES, default 180, meaning framebuffer height in pixels.
REQ-004 The module SHALL use derived widths HWIDTH=$clog2(FB_HRES), VWIDTH=$clog2(FB_VRES), AWIDTH=$clog2(FB_HRES*FB_VRES) and depth count NPIX=FB_HRES*FB_VRES.
REQ-005 The module SHALL have ports:
- clk_in  input  1  the one clock; all state on its rising edge.
- rst_in  input  1  reset, asynchronous and active-high.
- clear_in  input  1  one-cycle request to reset the depth buffer.
- valid_in  input  1  pixel from the rasterizer is present.
- ready_out  output  1  stage accepts a pixel this cycle.
- hcount_in  input  HWIDTH  pixel column.
- vcount_in  input  VWIDTH  pixel row.
- addr_in  input  AWIDTH  linear pixel address.
- z_in  input  ZWIDTH  signed interpolated depth.
- last_in  input  1  final pixel of the triangle.
- valid_out  output  1  passing pixel offered to the shader/framebuffer.
- ready_in  input  1  downstream accepts.
- hcount_out, vcount_out, addr_out, z_out  output  HWIDTH/VWIDTH/AWIDTH/ZWIDTH  passing pixel fields.
- last_out  output  1  one-cycle pulse when the last_in pixel leaves S2, pass or fail.
- clearing_out  output  1  high while in state CLEAR.

Function
REQ-006 The module SHALL hold an internal NPIX x ZWIDTH depth RAM with one read port and one write port, and a read latency of 2 cycles.
REQ-007 The module SHALL implement states RUN, DRAIN and CLEAR.
REQ-008 A pixel SHALL be accepted when valid_in && ready_out.
REQ-009 ready_out SHALL equal (state==RUN) && !stall.
REQ-010 The pipeline SHALL have stages S0 (read issued), S1 and S2 (compare), so an accepted pixel reaches S2 two cycles later.
REQ-011 A pixel SHALL pass when the signed z_in is strictly less than the effective stored depth; an equal depth fails.
REQ-012 The effective stored depth SHALL be the RAM read data unless the address matches a write made in either of the two preceding write cycles.
REQ-013 On such a match the most recent matching write value SHALL be used (read-after-write forwarding).
REQ-014 On pass, S2 SHALL write z to the RAM at addr.
REQ-015 On pass, S2 SHALL drive valid_out=1 with the fields of that pixel.
REQ-016 The RAM write of REQ-014 SHALL occur in the cycle the output handshake (valid_out && ready_in) completes.
REQ-017 A failing pixel SHALL be dropped with no write and no valid_out.
REQ-018 stall SHALL equal S2 valid && pass && !ready_in.
REQ-019 While stall is high, S0/S1/S2, the RAM output registers and the forwarding history SHALL hold.
REQ-020 While stall is high, the output fields SHALL stay stable.
REQ-021 last_out SHALL pulse once per last_in pixel, in the cycle that pixel leaves S2.
REQ-022 clear_in in RUN SHALL move the state to DRAIN.
REQ-023 DRAIN SHALL hold ready_out=0 until S0..S2 are empty, then move to CLEAR.
REQ-024 CLEAR SHALL write ZMAX (0 followed by all 1s, the maximum positive value) to addresses 0..NPIX-1, one per cycle.
REQ-025 After the write to NPIX-1, CLEAR SHALL return to RUN, so CLEAR lasts exactly NPIX cycles.
REQ-026 clear_in during DRAIN or CLEAR SHALL be ignored.
REQ-027 Clearing SHALL also flush the forwarding history.

Reset
REQ-028 Asserting rst_in SHALL immediately force state CLEAR with clear address 0.
REQ-029 Asserting rst_in SHALL immediately empty all pipeline valids and the forwarding history.
REQ-030 Asserting rst_in SHALL immediately force valid_out=0 and last_out=0.
REQ-031 Asserting rst_in SHALL immediately force clearing_out=1 and ready_out=0.
REQ-032 Asserting rst_in SHALL immediately force hcount_out, vcount_out, addr_out and z_out to 0.
REQ-033 The RAM contents SHALL NOT be reset directly; they become ZMAX through the CLEAR sweep.
REQ-034 A reset mid-frame or mid-clear SHALL restart the sweep at address 0.

Verification
REQ-035 The bench SHALL cover: release reset, then count cycles -> clearing_out high for exactly 57600 cycles, then ready_out=1.
REQ-036 The bench SHALL cover: pixel addr=5, z=100, then addr=5, z=200, then addr=5, z=50 back-to-back, ready_in=1 -> valid_out for z=100 and z=50 only (forwarding exercised).
REQ-037 The bench SHALL cover: a passing pixel with ready_in=0 for 4 cycles -> valid_out held with fields stable, ready_out=0, then one transfer on release.
REQ-038 The bench SHALL cover: last_in on a failing pixel (z=ZMAX against a cleared buffer) -> last_out pulse for exactly 1 cycle and valid_out=0.
REQ-039 The bench SHALL cover: clear_in with 2 pixels in flight -> both complete, then DRAIN, CLEAR, and addr 5 reads ZMAX afterwards (z=ZMAX-1 passes).
REQ-040 The bench SHALL cover: rst_in asserted mid-clear at address 1000 -> outputs zero asynchronously and the sweep restarts at 0.

Source files
------------

// File: rtl/depth_test_stage_if.sv
// Pixel stream interface for depth_test_stage.
// The interface carries three groups of signals:
//   - the rasterizer-side input stream,
//   - the shader/framebuffer-side output stream,
//   - clear control and status.
// The master modport is the environment (rasterizer plus downstream consumer).
// The slave modport is the depth-test stage itself.
interface depth_test_stage_if #(
  parameter int ZWIDTH  = 16,
  parameter int FB_HRES = 320,
  parameter int FB_VRES = 180
);
  localparam int HWIDTH = $clog2(FB_HRES);
  localparam int VWIDTH = $clog2(FB_VRES);
  localparam int AWIDTH = $clog2(FB_HRES * FB_VRES);

  // Clear control and status
  logic                     clear_in;
  logic                     clearing_out;

  // Input pixel stream
  logic                     valid_in;
  logic                     ready_out;
  logic        [HWIDTH-1:0] hcount_in;
  logic        [VWIDTH-1:0] vcount_in;
  logic        [AWIDTH-1:0] addr_in;
  logic signed [ZWIDTH-1:0] z_in;
  logic                     last_in;

  // Output pixel stream
  logic                     valid_out;
  logic                     ready_in;
  logic        [HWIDTH-1:0] hcount_out;
  logic        [VWIDTH-1:0] vcount_out;
  logic        [AWIDTH-1:0] addr_out;
  logic signed [ZWIDTH-1:0] z_out;
  logic                     last_out;

  modport master (
    output clear_in, valid_in, hcount_in, vcount_in, addr_in, z_in, last_in, ready_in,
    input  ready_out, valid_out, hcount_out, vcount_out, addr_out, z_out, last_out,
           clearing_out
  );

  modport slave (
    input  clear_in, valid_in, hcount_in, vcount_in, addr_in, z_in, last_in, ready_in,
    output ready_out, valid_out, hcount_out, vcount_out, addr_out, z_out, last_out,
           clearing_out
  );
endinterface

// File: rtl/depth_test_stage.sv
// Depth-test stage between the rasterizer and the shader/framebuffer.
//
// Pipeline:
//   - S0 issues the depth-RAM read (two-cycle read latency).
//   - S1 waits for the read data.
//   - S2 compares the pixel depth against the stored depth.
//
// Writes made by S2 in the two most recent pipeline steps are forwarded,
// because the RAM data seen in S2 predates them.
//
// A clear request drains the pipeline, then sweeps ZMAX into every entry.
module depth_test_stage #(
  parameter int ZWIDTH  = 16,
  parameter int FB_HRES = 320,
  parameter int FB_VRES = 180
) (
  input  logic               clk_in,
  input  logic               rst_in,
  depth_test_stage_if.slave  pix
);
  localparam int HWIDTH = $clog2(FB_HRES);
  localparam int VWIDTH = $clog2(FB_VRES);
  localparam int AWIDTH = $clog2(FB_HRES * FB_VRES);
  localparam int NPIX   = FB_HRES * FB_VRES;
  localparam logic signed [ZWIDTH-1:0] ZMAX = {1'b0, {(ZWIDTH-1){1'b1}}};

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  typedef struct packed {
    logic        [HWIDTH-1:0] hcount;
    logic        [VWIDTH-1:0] vcount;
    logic        [AWIDTH-1:0] addr;
    logic signed [ZWIDTH-1:0] z;
    logic                     last;
  } pix_t;

  typedef struct packed {
    logic                     valid;
    logic        [AWIDTH-1:0] addr;
    logic signed [ZWIDTH-1:0] z;
  } wr_t;

  state_t                   state_q, state_d;
  logic        [AWIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                     s0_v_q, s1_v_q, s2_v_q;
  pix_t                     s0_q, s1_q, s2_q;
  wr_t                      hist1_q, hist2_q;  // hist1 is the most recent step
  logic signed [ZWIDTH-1:0] rd1_q, rd2_q;
  logic signed [ZWIDTH-1:0] mem [NPIX];

  logic signed [ZWIDTH-1:0] eff_z;
  logic                     pass, stall, advance, accept, out_fire;
  logic                     wr_en;
  logic        [AWIDTH-1:0] wr_addr;
  logic signed [ZWIDTH-1:0] wr_data;

  assign pass     = s2_v_q && (s2_q.z < eff_z);
  assign stall    = pass && !pix.ready_in;
  assign advance  = !stall;
  assign out_fire = pass && pix.ready_in;
  assign accept   = pix.valid_in && pix.ready_out;

  assign pix.ready_out    = (state_q == RUN) && !stall;
  assign pix.valid_out    = pass;
  assign pix.last_out     = s2_v_q && s2_q.last && !stall;
  assign pix.clearing_out = (state_q == CLEAR);
  assign pix.hcount_out   = s2_q.hcount;
  assign pix.vcount_out   = s2_q.vcount;
  assign pix.addr_out     = s2_q.addr;
  assign pix.z_out        = s2_q.z;

  // Effective stored depth: newest matching forwarded write wins over RAM data.
  // NOTE: every always_comb output gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    eff_z = rd2_q;
    if (hist2_q.valid && (hist2_q.addr == s2_q.addr)) eff_z = hist2_q.z;
    if (hist1_q.valid && (hist1_q.addr == s2_q.addr)) eff_z = hist1_q.z;
  end

  // Single RAM write port: the clear sweep, or a passing pixel leaving S2.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s2_q.addr;
    wr_data = s2_q.z;
    if (state_q == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr_q;
      wr_data = ZMAX;
    end else if (out_fire) begin
      wr_en = 1'b1;
    end
  end

  // Next state: RUN -> DRAIN on clear, DRAIN -> CLEAR when empty,
  // CLEAR -> RUN after the last address.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      RUN:   if (pix.clear_in) state_d = DRAIN;
      DRAIN: if (!(s0_v_q || s1_v_q || s2_v_q)) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
             end
      CLEAR: begin
               clr_addr_d = clr_addr_q + AWIDTH'(1);
               if (clr_addr_q == AWIDTH'(NPIX - 1)) begin
                 state_d    = RUN;
                 clr_addr_d = '0;
               end
             end
      default: state_d = CLEAR;
    endcase
  end

  // State register and clear-address counter; reset restarts the sweep at 0.
  // NOTE: sequential state uses non-blocking assignments, so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Pipeline S0 -> S1 -> S2; everything holds while the output is stalled.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s0_v_q <= 1'b0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s0_q   <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
    end else if (advance) begin
      s0_v_q <= accept;
      s1_v_q <= s0_v_q;
      s2_v_q <= s1_v_q;
      s0_q   <= '{hcount: pix.hcount_in, vcount: pix.vcount_in, addr: pix.addr_in,
                  z: pix.z_in, last: pix.last_in};
      s1_q   <= s0_q;
      s2_q   <= s1_q;
    end
  end

  // Forwarding history: one entry per pipeline step, flushed while clearing.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hist1_q <= '0;
      hist2_q <= '0;
    end else if (state_q == CLEAR) begin
      hist1_q <= '0;
      hist2_q <= '0;
    end else if (advance) begin
      hist1_q <= '{valid: out_fire, addr: s2_q.addr, z: s2_q.z};
      hist2_q <= hist1_q;
    end
  end

  // Depth RAM with a two-stage registered read that holds under stall.
  // NOTE: the RAM and its read registers have no reset; the CLEAR sweep
  // initialises the contents, and the read data is only used alongside a valid S2.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (advance) begin
      rd1_q <= mem[s0_q.addr];
      rd2_q <= rd1_q;
    end
  end
endmodule
